muldiv_iter: RTL and testbench

Parametrised iterative multiply/divide unit. It is the next-generation replacement for the fixed 32-bit divider in the EX stage. It supports signed and unsigned multiply and divide at any operand width and uses a single start/annul/ready handshake. The unit returns a 2*WIDTH result, {hi, lo}, which EX forwards to the hilo path. EX stalls (stallreq) while the unit is busy; ctrl's flush drives annul_i.

---
 rtl/muldiv_iter_if.sv | 34 +++
 rtl/muldiv_iter.sv | 202 ++++++++++++++++++++
 tb/tb_muldiv_iter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_iter_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_iter_if
// Description : Request/response bundle between the EX stage and the
//               iterative multiply/divide unit.
// Revision    : 1.0  initial release
// ============================================================================
interface muldiv_iter_if #(
    parameter int WIDTH = 32
);
    logic                 op_div_i;
    logic                 signed_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 start_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 busy_o;
    logic                 div_zero_o;

    // Requester side (EX stage)
    modport master (
        output op_div_i, signed_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, busy_o, div_zero_o
    );

    // Arithmetic unit side
    modport slave (
        input  op_div_i, signed_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, busy_o, div_zero_o
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_iter
// Description : Iterative signed/unsigned multiply (shift-add) and divide
//               (restoring radix-2), one bit per cycle, returning a
//               2*WIDTH {hi, lo} result.
// Revision    : 1.0  initial release
// ============================================================================
module muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  wire logic     clk,
    input  wire logic     rst,      // asynchronous, active low
    muldiv_iter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ZERO = 2'd1,
        S_BUSY = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(WIDTH - 1);

    state_t               state_q,    state_d;
    logic                 op_div_q,   op_div_d;
    logic                 q_sign_q,   q_sign_d;   // quotient / product sign
    logic                 r_sign_q,   r_sign_d;   // remainder sign (dividend's)
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    // Divide: {partial remainder[WIDTH:0], dividend/quotient[WIDTH-1:0]}.
    // Multiply: {0, product_hi, multiplier/product_lo}.
    // Divide-by-zero: low half carries the raw dividend for the result.
    logic [2*WIDTH:0]     acc_q,      acc_d;
    logic [WIDTH-1:0]     opa_q,      opa_d;      // divisor or multiplicand magnitude
    logic [2*WIDTH-1:0]   result_q,   result_d;
    logic                 div_zero_q, div_zero_d;

    logic [WIDTH-1:0]     w_mag1;
    logic [WIDTH-1:0]     w_mag2;
    logic [2*WIDTH:0]     w_sh;
    logic [WIDTH+1:0]     w_diff;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH:0]     w_step;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_final;

    // Operand magnitudes taken straight from the request inputs
    always_comb begin
        w_mag1 = bus.opdata1_i;
        w_mag2 = bus.opdata2_i;
        if (bus.signed_i && bus.opdata1_i[WIDTH-1]) begin
            w_mag1 = -bus.opdata1_i;
        end
        if (bus.signed_i && bus.opdata2_i[WIDTH-1]) begin
            w_mag2 = -bus.opdata2_i;
        end
    end

    // One iteration of the shared datapath plus final sign correction
    always_comb begin
        w_sh   = {acc_q[2*WIDTH-1:0], 1'b0};
        // Extra top bit makes the borrow visible even when the shifted
        // partial remainder uses all WIDTH+1 bits.
        w_diff = {1'b0, w_sh[2*WIDTH:WIDTH]} - {2'b00, opa_q};
        w_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
               + (acc_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});

        if (op_div_q) begin
            if (!w_diff[WIDTH+1]) begin
                w_step = {w_diff[WIDTH:0], w_sh[WIDTH-1:1], 1'b1};
            end else begin
                w_step = w_sh;
            end
        end else begin
            w_step = {1'b0, w_sum, acc_q[WIDTH-1:1]};
        end

        w_quot = w_step[WIDTH-1:0];
        w_rem  = w_step[2*WIDTH-1:WIDTH];
        w_prod = w_step[2*WIDTH-1:0];
        if (q_sign_q) begin
            w_quot = -w_step[WIDTH-1:0];
            w_prod = -w_step[2*WIDTH-1:0];
        end
        if (r_sign_q) begin
            w_rem = -w_step[2*WIDTH-1:WIDTH];
        end

        w_final = op_div_q ? {w_rem, w_quot} : w_prod;
    end

    // Next-state and register-update logic of the control FSM
    always_comb begin
        state_d    = state_q;
        op_div_d   = op_div_q;
        q_sign_d   = q_sign_q;
        r_sign_d   = r_sign_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opa_d      = opa_q;
        result_d   = result_q;
        div_zero_d = div_zero_q;

        if (bus.annul_i) begin
            // A flush overrides everything, including a simultaneous start
            state_d    = S_IDLE;
            result_d   = '0;
            div_zero_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        op_div_d   = bus.op_div_i;
                        q_sign_d   = bus.signed_i
                                   & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
                        r_sign_d   = bus.signed_i & bus.opdata1_i[WIDTH-1];
                        cnt_d      = '0;
                        result_d   = '0;
                        div_zero_d = 1'b0;
                        if (bus.op_div_i && (bus.opdata2_i == '0)) begin
                            opa_d   = '0;
                            acc_d   = {{(WIDTH+1){1'b0}}, bus.opdata1_i};
                            state_d = S_ZERO;
                        end else if (bus.op_div_i) begin
                            opa_d   = w_mag2;
                            acc_d   = {{(WIDTH+1){1'b0}}, w_mag1};
                            state_d = S_BUSY;
                        end else begin
                            opa_d   = w_mag1;
                            acc_d   = {{(WIDTH+1){1'b0}}, w_mag2};
                            state_d = S_BUSY;
                        end
                    end
                end

                S_ZERO: begin
                    result_d   = {acc_q[WIDTH-1:0], {WIDTH{1'b1}}};
                    div_zero_d = 1'b1;
                    state_d    = S_DONE;
                end

                S_BUSY: begin
                    acc_d = w_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == C_LAST_ITER) begin
                        result_d = w_final;
                        state_d  = S_DONE;
                    end
                end

                S_DONE: begin
                    // Hold the result until the requester drops start
                    if (!bus.start_i) begin
                        result_d   = '0;
                        div_zero_d = 1'b0;
                        state_d    = S_IDLE;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            op_div_q   <= 1'b0;
            q_sign_q   <= 1'b0;
            r_sign_q   <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            opa_q      <= '0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_div_q   <= op_div_d;
            q_sign_q   <= q_sign_d;
            r_sign_q   <= r_sign_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opa_q      <= opa_d;
            result_q   <= result_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.result_o   = result_q;
    assign bus.div_zero_o = div_zero_q;
    assign bus.ready_o    = (state_q == S_DONE);
    assign bus.busy_o     = (state_q == S_ZERO) || (state_q == S_BUSY);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_iter
// Description : Self-checking bench for muldiv_iter at WIDTH=32 and WIDTH=8.
// Revision    : 1.0  initial release
// ============================================================================
module tb_muldiv_iter;

    logic clk;
    logic rst_n;

    typedef struct {
        logic [63:0] res;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    muldiv_iter_if #(.WIDTH(32)) if32 ();
    muldiv_iter_if #(.WIDTH(8))  if8  ();

    muldiv_iter #(.WIDTH(32), .CNT_W(6)) dut32 (
        .clk (clk),
        .rst (rst_n),
        .bus (if32.slave)
    );

    muldiv_iter #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk (clk),
        .rst (rst_n),
        .bus (if8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input bit narrow);
        return narrow ? if8.ready_o : if32.ready_o;
    endfunction

    function automatic logic bsy(input bit narrow);
        return narrow ? if8.busy_o : if32.busy_o;
    endfunction

    function automatic logic [63:0] res(input bit narrow);
        return narrow ? {56'd0, if8.result_o} : if32.result_o;
    endfunction

    function automatic logic dzo(input bit narrow);
        return narrow ? if8.div_zero_o : if32.div_zero_o;
    endfunction

    task automatic drive(input bit narrow, input bit div, input bit sgn,
                         input logic [31:0] a, input logic [31:0] b, input bit st);
        if (narrow) begin
            if8.op_div_i  = div;
            if8.signed_i  = sgn;
            if8.opdata1_i = a[7:0];
            if8.opdata2_i = b[7:0];
            if8.start_i   = st;
        end else begin
            if32.op_div_i  = div;
            if32.signed_i  = sgn;
            if32.opdata1_i = a;
            if32.opdata2_i = b;
            if32.start_i   = st;
        end
    endtask

    task automatic set_start(input bit narrow, input bit st);
        if (narrow) if8.start_i = st;
        else        if32.start_i = st;
    endtask

    // Issue one operation, hold start until ready, then check the handshake
    task automatic run_op(input string tag, input bit narrow, input bit div, input bit sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_res, input bit exp_dz, input int exp_lat);
        exp_t e;
        int   n;
        bit   busy_ok;
        e.res = exp_res;
        e.dz  = exp_dz;
        e.lat = exp_lat;
        sb.push_back(e);

        drive(narrow, div, sgn, a, b, 1'b1);
        busy_ok = 1'b1;
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (i == 1) begin
                // Operands are don't-care once accepted
                drive(narrow, ~div, ~sgn, $urandom, $urandom, 1'b1);
            end
            n = i;
            if (rdy(narrow)) break;
            if (!bsy(narrow)) busy_ok = 1'b0;
        end

        e = sb.pop_front();
        chk({tag, " latency"},  64'(n),           64'(e.lat));
        chk({tag, " result"},   res(narrow),      e.res);
        chk({tag, " div_zero"}, 64'(dzo(narrow)), 64'(e.dz));
        chk({tag, " busy_run"}, 64'(busy_ok),     64'd1);
        chk({tag, " busy_done"},64'(bsy(narrow)), 64'd0);

        // start still high: result held, no restart
        tick();
        chk({tag, " hold_ready"},  64'(rdy(narrow)), 64'd1);
        chk({tag, " hold_result"}, res(narrow),      e.res);

        set_start(narrow, 1'b0);
        tick();
        chk({tag, " drop_ready"},  64'(rdy(narrow)), 64'd0);
        chk({tag, " drop_result"}, res(narrow),      64'd0);
        chk({tag, " drop_dz"},     64'(dzo(narrow)), 64'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        bit          seen;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        if32.annul_i = 1'b0;
        if8.annul_i  = 1'b0;
        tick();
        tick();
        chk("reset ready",  64'(if32.ready_o),    64'd0);
        chk("reset busy",   64'(if32.busy_o),     64'd0);
        chk("reset result", if32.result_o,        64'd0);
        chk("reset dz",     64'(if32.div_zero_o), 64'd0);
        rst_n = 1'b1;
        tick();

        // 32-bit directed cases
        run_op("udiv 100/7", 1'b0, 1'b1, 1'b0, 32'd100, 32'd7,
               64'h00000002_0000000E, 1'b0, 33);
        run_op("sdiv -7/2", 1'b0, 1'b1, 1'b1, -32'sd7, 32'd2,
               64'hFFFFFFFF_FFFFFFFD, 1'b0, 33);
        run_op("sdiv 7/-2", 1'b0, 1'b1, 1'b1, 32'd7, -32'sd2,
               64'h00000001_FFFFFFFD, 1'b0, 33);
        run_op("smul -3*5", 1'b0, 1'b0, 1'b1, -32'sd3, 32'd5,
               64'hFFFFFFFF_FFFFFFF1, 1'b0, 33);
        run_op("umul max*max", 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,
               64'hFFFFFFFE_00000001, 1'b0, 33);
        run_op("div by zero", 1'b0, 1'b1, 1'b0, 32'h12345678, 32'd0,
               64'h12345678_FFFFFFFF, 1'b1, 2);

        // 8-bit boundary cases
        run_op("w8 sdiv 80/FF", 1'b1, 1'b1, 1'b1, 32'h80, 32'hFF, 64'h0080, 1'b0, 9);
        run_op("w8 sdiv 80/01", 1'b1, 1'b1, 1'b1, 32'h80, 32'h01, 64'h0080, 1'b0, 9);
        run_op("w8 smul -3*5",  1'b1, 1'b0, 1'b1, 32'hFD, 32'h05, 64'hFFF1, 1'b0, 9);
        run_op("w8 sdiv -7/2",  1'b1, 1'b1, 1'b1, 32'hF9, 32'h02, 64'hFFFD, 1'b0, 9);

        // Random unsigned cases checked against native arithmetic
        for (int k = 0; k < 3; k++) begin
            ra = $urandom;
            rb = $urandom | 32'd1;
            run_op("rand umul", 1'b0, 1'b0, 1'b0, ra, rb, 64'(ra) * 64'(rb), 1'b0, 33);
            run_op("rand udiv", 1'b0, 1'b1, 1'b0, ra, rb, {ra % rb, ra / rb}, 1'b0, 33);
        end

        // Annul in the middle of a divide
        drive(1'b0, 1'b1, 1'b0, 32'd1000, 32'd3, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        chk("annul pre busy", 64'(if32.busy_o), 64'd1);
        if32.annul_i = 1'b1;
        if32.start_i = 1'b0;
        tick();
        if32.annul_i = 1'b0;
        chk("annul busy",   64'(if32.busy_o),  64'd0);
        chk("annul ready",  64'(if32.ready_o), 64'd0);
        chk("annul result", if32.result_o,     64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (if32.ready_o || if32.busy_o) seen = 1'b1;
        end
        chk("annul no ready", 64'(seen), 64'd0);

        // Start coinciding with annul is ignored
        drive(1'b0, 1'b1, 1'b0, 32'd50, 32'd5, 1'b1);
        if32.annul_i = 1'b1;
        tick();
        chk("start+annul busy", 64'(if32.busy_o), 64'd0);
        if32.annul_i = 1'b0;
        if32.start_i = 1'b0;
        tick();

        run_op("udiv 9/3", 1'b0, 1'b1, 1'b0, 32'd9, 32'd3,
               64'h00000000_00000003, 1'b0, 33);

        // Asynchronous reset mid-operation
        drive(1'b0, 1'b1, 1'b0, 32'd100, 32'd7, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        chk("rst pre busy", 64'(if32.busy_o), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst busy",  64'(if32.busy_o),  64'd0);
        chk("async rst ready", 64'(if32.ready_o), 64'd0);
        if32.start_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Asynchronous reset while a result is being held
        drive(1'b0, 1'b1, 1'b0, 32'h12345678, 32'd0, 1'b1);
        tick();
        tick();
        chk("rst pre ready", 64'(if32.ready_o), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst done ready",  64'(if32.ready_o),    64'd0);
        chk("async rst done result", if32.result_o,        64'd0);
        chk("async rst done dz",     64'(if32.div_zero_o), 64'd0);
        if32.start_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
